hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequential successor to the combinational ID-stage hazard detector.
- Detects load-use hazards between IF/ID and ID/EX and holds the stall for a parametrised number of cycles.
- Flushes IF/ID on a taken branch, and drains the pipeline on HALT before asserting a sticky halted flag.
- Counts stall cycles for debug readout. Sits beside the ID stage and drives PC/IF-ID write enables and the ID/EX bubble mux.

Parameters:
- NB_REG, 5, register-index width
- NB_OP, 6, opcode width
- CODE_OP_HALT, 6'b111111, opcode that starts the halt drain
- LOAD_STALL_CYCLES, 1, total stall cycles per load-use hazard (>=1)
- HALT_DRAIN_CYCLES, 3, bubble cycles inserted after HALT before halted (>=1)
- NB_STALL_CNT, 16, width of the stall-cycle counter

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline step enable (debug unit); 0 freezes the block
- i_if_id_rs  in  NB_REG  rs of the instruction in ID
- i_if_id_rt  in  NB_REG  rt of the instruction in ID
- i_if_id_op  in  NB_OP  opcode of the instruction in ID
- i_id_ex_rt  in  NB_REG  destination rt of the instruction in EX
- i_id_ex_mem_read  in  1  instruction in EX is a load (decoded control)
- i_branch_taken  in  1  branch/jump resolved taken in ID this cycle
- o_pc_write  out  1  PC update enable
- o_if_id_write  out  1  IF/ID register write enable
- o_id_ex_bubble  out  1  select NOP controls into ID/EX
- o_if_id_flush  out  1  clear IF/ID to NOP on the next edge
- o_halt  out  1  sticky: program drained and halted
- o_stall_cycles  out  NB_STALL_CNT  saturating count of load-use stall cycles

Behaviour:
- The design has one clock; reset is synchronous and active-high.
- Hazard: hz = i_id_ex_mem_read && i_id_ex_rt != 0 && (i_id_ex_rt == i_if_id_rs || i_id_ex_rt == i_if_id_rt). Register $zero never hazards.
- Stall output set: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1, o_if_id_flush=0.
- Normal output set: o_pc_write=1, o_if_id_write=1, o_id_ex_bubble=0.
- FSM states: RUN, LOAD_STALL, DRAIN, HALTED. Down-counter cnt has width clog2 of max(LOAD_STALL_CYCLES, HALT_DRAIN_CYCLES)+1.
- RUN, priority HALT > hz > branch:
  - i_if_id_op == CODE_OP_HALT: stall outputs (Mealy). If HALT_DRAIN_CYCLES == 1, next state HALTED; else next state DRAIN with cnt = HALT_DRAIN_CYCLES-1.
  - hz: stall outputs (Mealy); o_stall_cycles += 1. If LOAD_STALL_CYCLES > 1, next state LOAD_STALL with cnt = LOAD_STALL_CYCLES-1; else stay in RUN.
  - else: normal outputs, o_if_id_flush = i_branch_taken.
- Branch during a stall: a taken branch coinciding with hz or HALT is ignored (flush=0). The branch re-resolves once the stall clears.
- LOAD_STALL: stall outputs, hazard inputs ignored, o_stall_cycles += 1. cnt decrements each enabled cycle. When cnt == 1, next state RUN.
  - Total stall length is exactly LOAD_STALL_CYCLES enabled cycles, including the detection cycle.
- DRAIN: stall outputs, all hazard and branch inputs ignored. When cnt == 1, next state HALTED; else cnt decrements.
- HALTED: o_halt=1 (registered, set on entry edge). Stall outputs held. Leaves only on reset.
- o_halt rises one cycle after the last drain bubble.
- i_enable=0:
  - state, cnt and o_stall_cycles hold;
  - o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=0, o_if_id_flush=0;
  - o_halt holds its value.
  - A pause mid-stall resumes with the remaining count intact.
- o_stall_cycles saturates at all-ones and does not wrap.
- While i_reset=1: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1, o_if_id_flush=0. On the edge, state=RUN, cnt=0, o_halt=0, o_stall_cycles=0.
- Reset mid-LOAD_STALL or mid-DRAIN, or in HALTED, returns to RUN with no residual stall. Reset has priority over i_enable.

Test Plan:
- Default params. EX: mem_read=1, rt=5; ID: rs=5. -> one cycle with pc_write=0/if_id_write=0/bubble=1, then normal outputs; o_stall_cycles=1.
- Same stimulus with id_ex_rt=0, or rt=5 vs rs=6, rt=7. -> no stall; o_stall_cycles stays 0.
- LOAD_STALL_CYCLES=3, hazard on rt=7. -> exactly 3 stall cycles. Drop i_enable for 2 cycles mid-stall: outputs idle, stall resumes with the correct remainder; o_stall_cycles=3.
- i_branch_taken=1 alone -> o_if_id_flush=1 for one cycle. Branch together with a hazard -> flush=0 and stall asserted.
- HALT opcode in ID, HALT_DRAIN_CYCLES=3. -> 3 bubble cycles, o_halt=1 on the following cycle, stays 1 with later branches/hazards ignored. i_reset -> o_halt=0, RUN.
- NB_STALL_CNT=2, five separate hazards -> o_stall_cycles saturates at 3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Load-use / branch / halt hazard controller beside the ID stage.
// Drives PC and IF/ID write enables, the ID/EX bubble mux, the IF/ID flush and a sticky halt flag.
module hazard_stall_controller #(
  parameter int              NB_REG            = 5,
  parameter int              NB_OP             = 6,
  parameter logic [NB_OP-1:0] CODE_OP_HALT     = {NB_OP{1'b1}},
  parameter int              LOAD_STALL_CYCLES = 1,
  parameter int              HALT_DRAIN_CYCLES = 3,
  parameter int              NB_STALL_CNT      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [NB_REG-1:0]       i_if_id_rs,
  input  logic [NB_REG-1:0]       i_if_id_rt,
  input  logic [NB_OP-1:0]        i_if_id_op,
  input  logic [NB_REG-1:0]       i_id_ex_rt,
  input  logic                    i_id_ex_mem_read,
  input  logic                    i_branch_taken,
  output logic                    o_pc_write,
  output logic                    o_if_id_write,
  output logic                    o_id_ex_bubble,
  output logic                    o_if_id_flush,
  output logic                    o_halt,
  output logic [NB_STALL_CNT-1:0] o_stall_cycles
);

  localparam int MAX_CYCLES = (LOAD_STALL_CYCLES > HALT_DRAIN_CYCLES) ?
                              LOAD_STALL_CYCLES : HALT_DRAIN_CYCLES;
  localparam int NB_CNT     = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    DRAIN      = 2'd2,
    HALTED     = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [NB_CNT-1:0] cnt, cnt_next;
  logic              count_stall;
  logic              hazard;
  logic              halt_op;

  // $zero is hardwired, so a load targeting it never creates a dependency.
  assign hazard  = i_id_ex_mem_read && (i_id_ex_rt != '0) &&
                   ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
  assign halt_op = (i_if_id_op == CODE_OP_HALT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_next     = state;
    cnt_next       = cnt;
    count_stall    = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_id_ex_bubble = 1'b1;
    o_if_id_flush  = 1'b0;

    case (state)
      RUN: begin
        if (halt_op) begin
          if (HALT_DRAIN_CYCLES == 1) begin
            state_next = HALTED;
          end else begin
            state_next = DRAIN;
            cnt_next   = NB_CNT'(HALT_DRAIN_CYCLES - 1);
          end
        end else if (hazard) begin
          count_stall = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_next = LOAD_STALL;
            cnt_next   = NB_CNT'(LOAD_STALL_CYCLES - 1);
          end
        end else begin
          o_pc_write     = 1'b1;
          o_if_id_write  = 1'b1;
          o_id_ex_bubble = 1'b0;
          o_if_id_flush  = i_branch_taken;
        end
      end
      LOAD_STALL: begin
        count_stall = 1'b1;
        cnt_next    = cnt - NB_CNT'(1);
        if (cnt == NB_CNT'(1)) state_next = RUN;
      end
      DRAIN: begin
        if (cnt == NB_CNT'(1)) state_next = HALTED;
        else                   cnt_next   = cnt - NB_CNT'(1);
      end
      default: ;
    endcase

    // A frozen pipeline sees idle controls; reset overrides with a safe bubble.
    if (i_reset) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_if_id_flush  = 1'b0;
    end else if (!i_enable) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_bubble = 1'b0;
      o_if_id_flush  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (i_reset) begin
      state          <= RUN;
      cnt            <= '0;
      o_halt         <= 1'b0;
      o_stall_cycles <= '0;
    end else if (i_enable) begin
      state  <= state_next;
      cnt    <= cnt_next;
      o_halt <= (state_next == HALTED);
      if (count_stall && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + NB_STALL_CNT'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: three controller instances (default, 3-cycle load stall, 2-bit counter) share stimulus.
module tb_hazard_stall_controller;

  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [3:0] C_STALL = 4'b0010;  // {pc_write, if_id_write, bubble, flush}
  localparam logic [3:0] C_NORM  = 4'b1100;
  localparam logic [3:0] C_FLUSH = 4'b1101;
  localparam logic [3:0] C_IDLE  = 4'b0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic [5:0] if_id_op;
  logic       id_ex_mem_read, branch_taken;

  logic        a_pc_write, a_if_id_write, a_bubble, a_flush, a_halt;
  logic [15:0] a_stall_cycles;
  logic        b_pc_write, b_if_id_write, b_bubble, b_flush, b_halt;
  logic [15:0] b_stall_cycles;
  logic        c_pc_write, c_if_id_write, c_bubble, c_flush, c_halt;
  logic [1:0]  c_stall_cycles;

  logic [3:0] a_ctl, b_ctl, c_ctl;
  assign a_ctl = {a_pc_write, a_if_id_write, a_bubble, a_flush};
  assign b_ctl = {b_pc_write, b_if_id_write, b_bubble, b_flush};
  assign c_ctl = {c_pc_write, c_if_id_write, c_bubble, c_flush};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut_a (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt), .i_if_id_op(if_id_op),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_mem_read(id_ex_mem_read), .i_branch_taken(branch_taken),
    .o_pc_write(a_pc_write), .o_if_id_write(a_if_id_write), .o_id_ex_bubble(a_bubble),
    .o_if_id_flush(a_flush), .o_halt(a_halt), .o_stall_cycles(a_stall_cycles)
  );

  hazard_stall_controller #(.LOAD_STALL_CYCLES(3)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt), .i_if_id_op(if_id_op),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_mem_read(id_ex_mem_read), .i_branch_taken(branch_taken),
    .o_pc_write(b_pc_write), .o_if_id_write(b_if_id_write), .o_id_ex_bubble(b_bubble),
    .o_if_id_flush(b_flush), .o_halt(b_halt), .o_stall_cycles(b_stall_cycles)
  );

  hazard_stall_controller #(.NB_STALL_CNT(2)) dut_c (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt), .i_if_id_op(if_id_op),
    .i_id_ex_rt(id_ex_rt), .i_id_ex_mem_read(id_ex_mem_read), .i_branch_taken(branch_taken),
    .o_pc_write(c_pc_write), .o_if_id_write(c_if_id_write), .o_id_ex_bubble(c_bubble),
    .o_if_id_flush(c_flush), .o_halt(c_halt), .o_stall_cycles(c_stall_cycles)
  );

  task automatic idle_inputs();
    enable = 1'b1; if_id_rs = '0; if_id_rt = '0; if_id_op = '0;
    id_ex_rt = '0; id_ex_mem_read = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt);
    id_ex_mem_read = 1'b1; id_ex_rt = ex_rt; if_id_rs = rs; if_id_rt = rt;
  endtask

  // Inputs change 1 time unit after the rising edge; checks land 2 units after it.
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; idle_inputs(); cycle(); cycle(); reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; branch_taken = 1'b1; set_hazard(5'd5, 5'd5, 5'd0);
    cycle(); #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL reset_ctl: got %b expected %b", a_ctl, C_STALL); end
    idle_inputs(); reset = 1'b0; #1;
    checks++; if (a_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", a_halt); end
    checks++; if (a_stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", a_stall_cycles); end
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL reset_release_ctl: got %b expected %b", a_ctl, C_NORM); end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_hazard(5'd5, 5'd5, 5'd0); #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL load_use_stall: got %b expected %b", a_ctl, C_STALL); end
    cycle(); idle_inputs(); #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL load_use_resume: got %b expected %b", a_ctl, C_NORM); end
    checks++; if (a_stall_cycles !== 16'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", a_stall_cycles); end
  endtask

  task automatic test_no_hazard();
    apply_reset();
    set_hazard(5'd0, 5'd0, 5'd0); #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL zero_reg: got %b expected %b", a_ctl, C_NORM); end
    cycle();
    set_hazard(5'd5, 5'd6, 5'd7); #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL no_match: got %b expected %b", a_ctl, C_NORM); end
    cycle();
    set_hazard(5'd7, 5'd7, 5'd7); id_ex_mem_read = 1'b0; #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL not_load: got %b expected %b", a_ctl, C_NORM); end
    cycle(); idle_inputs(); #1;
    checks++; if (a_stall_cycles !== 16'd0) begin errors++; $display("FAIL no_hazard_count: got %0d expected 0", a_stall_cycles); end
  endtask

  task automatic test_multi_stall();
    apply_reset();
    set_hazard(5'd7, 5'd1, 5'd7); #1;
    checks++; if (b_ctl !== C_STALL) begin errors++; $display("FAIL multi_stall_1: got %b expected %b", b_ctl, C_STALL); end
    cycle(); idle_inputs(); #1;
    checks++; if (b_ctl !== C_STALL) begin errors++; $display("FAIL multi_stall_2: got %b expected %b", b_ctl, C_STALL); end
    cycle(); enable = 1'b0; #1;
    checks++; if (b_ctl !== C_IDLE) begin errors++; $display("FAIL multi_pause_1: got %b expected %b", b_ctl, C_IDLE); end
    cycle(); #1;
    checks++; if (b_ctl !== C_IDLE) begin errors++; $display("FAIL multi_pause_2: got %b expected %b", b_ctl, C_IDLE); end
    checks++; if (b_stall_cycles !== 16'd2) begin errors++; $display("FAIL multi_pause_count: got %0d expected 2", b_stall_cycles); end
    cycle(); enable = 1'b1; #1;
    checks++; if (b_ctl !== C_STALL) begin errors++; $display("FAIL multi_stall_3: got %b expected %b", b_ctl, C_STALL); end
    cycle(); #1;
    checks++; if (b_ctl !== C_NORM) begin errors++; $display("FAIL multi_resume: got %b expected %b", b_ctl, C_NORM); end
    checks++; if (b_stall_cycles !== 16'd3) begin errors++; $display("FAIL multi_count: got %0d expected 3", b_stall_cycles); end
    // Reset in the middle of the long stall must leave no residual bubble.
    set_hazard(5'd7, 5'd7, 5'd0); cycle(); idle_inputs();
    apply_reset();
    checks++; if (b_ctl !== C_NORM) begin errors++; $display("FAIL multi_reset_mid: got %b expected %b", b_ctl, C_NORM); end
  endtask

  task automatic test_branch();
    apply_reset();
    branch_taken = 1'b1; #1;
    checks++; if (a_ctl !== C_FLUSH) begin errors++; $display("FAIL branch_flush: got %b expected %b", a_ctl, C_FLUSH); end
    cycle(); branch_taken = 1'b0; #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL branch_clear: got %b expected %b", a_ctl, C_NORM); end
    branch_taken = 1'b1; set_hazard(5'd9, 5'd9, 5'd0); #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL branch_with_hazard: got %b expected %b", a_ctl, C_STALL); end
    cycle(); idle_inputs(); branch_taken = 1'b1; #1;
    checks++; if (a_ctl !== C_FLUSH) begin errors++; $display("FAIL branch_reresolve: got %b expected %b", a_ctl, C_FLUSH); end
    cycle(); idle_inputs();
  endtask

  task automatic test_halt();
    apply_reset();
    if_id_op = HALT_OP; branch_taken = 1'b1; #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL halt_bubble_1: got %b expected %b", a_ctl, C_STALL); end
    cycle(); if_id_op = '0; set_hazard(5'd3, 5'd3, 5'd3); #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL halt_bubble_2: got %b expected %b", a_ctl, C_STALL); end
    checks++; if (a_halt !== 1'b0) begin errors++; $display("FAIL halt_early_2: got %b expected 0", a_halt); end
    cycle(); idle_inputs(); branch_taken = 1'b1; #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL halt_bubble_3: got %b expected %b", a_ctl, C_STALL); end
    checks++; if (a_halt !== 1'b0) begin errors++; $display("FAIL halt_early_3: got %b expected 0", a_halt); end
    cycle(); #1;
    checks++; if (a_halt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", a_halt); end
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL halted_ctl: got %b expected %b", a_ctl, C_STALL); end
    set_hazard(5'd4, 5'd4, 5'd4); cycle(); cycle(); #1;
    checks++; if (a_halt !== 1'b1 || a_ctl !== C_STALL) begin errors++; $display("FAIL halt_sticky: got halt=%b ctl=%b expected halt=1 ctl=%b", a_halt, a_ctl, C_STALL); end
    checks++; if (a_stall_cycles !== 16'd0) begin errors++; $display("FAIL halt_no_count: got %0d expected 0", a_stall_cycles); end
    enable = 1'b0; cycle(); #1;
    checks++; if (a_halt !== 1'b1 || a_ctl !== C_IDLE) begin errors++; $display("FAIL halt_paused: got halt=%b ctl=%b expected halt=1 ctl=%b", a_halt, a_ctl, C_IDLE); end
    apply_reset();
    checks++; if (a_halt !== 1'b0 || a_ctl !== C_NORM) begin errors++; $display("FAIL halt_reset: got halt=%b ctl=%b expected halt=0 ctl=%b", a_halt, a_ctl, C_NORM); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      set_hazard(5'd2, 5'd2, 5'd0); cycle();
      idle_inputs(); cycle();
      if (i == 2) begin
        checks++; if (c_stall_cycles !== 2'd2) begin errors++; $display("FAIL sat_count_2: got %0d expected 2", c_stall_cycles); end
      end
    end
    checks++; if (c_stall_cycles !== 2'd3) begin errors++; $display("FAIL sat_count_5: got %0d expected 3", c_stall_cycles); end
    checks++; if (a_stall_cycles !== 16'd5) begin errors++; $display("FAIL wide_count_5: got %0d expected 5", a_stall_cycles); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multi_stall();
    test_branch();
    test_halt();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
